// File: rtl/qoa_slice_unpacker.sv
// qoa_slice_unpacker
//   Assembles 8 received bytes (MSB-first) into a 64-bit QOA slice and emits
//   its 20 dequantized residuals over a valid/ready handshake. Byte assembly
//   keeps running during emission, so the next slice can be collected while
//   the current one drains.
//
// Ports
//   sys_clk     : clock, all state changes on the rising edge
//   sys_rst_n   : asynchronous active-low reset
//   data_rdy    : one-cycle strobe qualifying byte_in
//   byte_in     : received slice byte
//   slice_clr   : synchronous realign, drops the partially assembled slice
//   res_valid   : res_value/res_index hold a residual
//   res_ready   : consumer accept (transfer on res_valid & res_ready)
//   res_value   : signed dequantized residual, OUT_W bits
//   res_index   : residual position 0..19
//   slice_done  : pulses in the cycle residual 19 is accepted
//   overflow    : sticky, a completed slice was dropped
module qoa_slice_unpacker #(
  parameter int OUT_W = 16
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    data_rdy,
  input  logic [7:0]              byte_in,
  input  logic                    slice_clr,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [OUT_W-1:0] res_value,
  output logic [4:0]              res_index,
  output logic                    slice_done,
  output logic                    overflow
);

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_cnt;
  logic [55:0] r_asm;
  logic [63:0] r_hold;
  logic [4:0]  r_idx;
  logic        r_ovf;

  logic        w_byte_ok;
  logic        w_cpl;
  logic [63:0] w_word;
  logic        w_xfer;
  logic        w_last;
  logic        w_load;
  logic        w_drop;

  logic [5:0]  w_shamt;
  logic [5:0]  w_base;
  logic [2:0]  w_q;
  logic [11:0] w_scale;
  logic [15:0] w_s16;
  logic [15:0] w_mag;
  logic signed [15:0] w_sres;

  // Slice completion: the 8th accepted byte; slice_clr suppresses the byte.
  always_comb begin
    w_byte_ok = data_rdy & ~slice_clr;
    w_cpl     = w_byte_ok & (r_cnt == 3'd7);
    w_word    = {r_asm, byte_in};
    w_xfer    = (r_state == EMIT) & res_ready;
    w_last    = w_xfer & (r_idx == 5'd19);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cpl) begin
          w_state_nxt = EMIT;
          w_load      = 1'b1;
        end
      end
      EMIT: begin
        // A slice finishing exactly as residual 19 leaves is taken over
        // seamlessly; finishing at any other point in EMIT it is dropped.
        if (w_last) begin
          if (w_cpl) w_load = 1'b1;
          else       w_state_nxt = IDLE;
        end else if (w_cpl) begin
          w_drop = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= IDLE;
    else            r_state <= w_state_nxt;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt  <= '0;
      r_asm  <= '0;
      r_hold <= '0;
      r_idx  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (slice_clr) begin
        r_cnt <= '0;
        r_asm <= '0;
      end else if (data_rdy) begin
        if (r_cnt == 3'd7) begin
          r_cnt <= '0;
          r_asm <= '0;
        end else begin
          r_cnt <= r_cnt + 3'd1;
          r_asm <= {r_asm[47:0], byte_in};
        end
      end

      if (w_load) begin
        r_hold <= w_word;
        r_idx  <= '0;
      end else if (w_last) begin
        r_idx  <= '0;
      end else if (w_xfer) begin
        r_idx  <= r_idx + 5'd1;
      end

      if (w_drop) r_ovf <= 1'b1;
    end
  end

  // Residual k occupies hold[59-3k -: 3].
  always_comb begin
    w_shamt = 6'(r_idx) * 6'd3;
    w_base  = 6'd59 - w_shamt;
    w_q     = r_hold[w_base -: 3];
  end

  always_comb begin
    case (r_hold[63:60])
      4'd0:    w_scale = 12'd1;
      4'd1:    w_scale = 12'd7;
      4'd2:    w_scale = 12'd21;
      4'd3:    w_scale = 12'd45;
      4'd4:    w_scale = 12'd84;
      4'd5:    w_scale = 12'd138;
      4'd6:    w_scale = 12'd211;
      4'd7:    w_scale = 12'd304;
      4'd8:    w_scale = 12'd421;
      4'd9:    w_scale = 12'd562;
      4'd10:   w_scale = 12'd731;
      4'd11:   w_scale = 12'd928;
      4'd12:   w_scale = 12'd1157;
      4'd13:   w_scale = 12'd1419;
      4'd14:   w_scale = 12'd1715;
      default: w_scale = 12'd2048;
    endcase
  end

  // Round-half-away magnitudes of S*{0.75, 2.5, 4.5, 7}; largest
  // intermediate is 9*2048+1, which fits 16 bits.
  always_comb begin
    w_s16 = {4'd0, w_scale};
    case (w_q[2:1])
      2'd0:    w_mag = (w_s16 * 16'd3 + 16'd2) >> 2;
      2'd1:    w_mag = (w_s16 * 16'd5 + 16'd1) >> 1;
      2'd2:    w_mag = (w_s16 * 16'd9 + 16'd1) >> 1;
      default: w_mag = w_s16 * 16'd7;
    endcase
    w_sres = w_q[0] ? (16'd0 - w_mag) : w_mag;
  end

  always_comb begin
    res_value = '0;
    if (r_state == EMIT) res_value = OUT_W'(w_sres);
  end

  assign res_valid  = (r_state == EMIT);
  assign res_index  = r_idx;
  assign slice_done = w_last;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_qoa_slice_unpacker.sv
// Scoreboarded bench for qoa_slice_unpacker: stimulus pushes expected
// residuals computed by a reference model; a monitor pops and compares on
// every handshake and checks stall stability.
module tb_qoa_slice_unpacker;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n;
  logic              data_rdy;
  logic [7:0]        byte_in;
  logic              slice_clr;
  logic              res_valid;
  logic              res_ready;
  logic signed [15:0] res_value;
  logic [4:0]        res_index;
  logic              slice_done;
  logic              overflow;

  qoa_slice_unpacker #(.OUT_W(16)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .data_rdy   (data_rdy),
    .byte_in    (byte_in),
    .slice_clr  (slice_clr),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_value  (res_value),
    .res_index  (res_index),
    .slice_done (slice_done),
    .overflow   (overflow)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int val;
    int idx;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   ready_mode = 0;  // 0: always ready, 1: random, 2: never ready

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference dequantizer: S times {0.75,2.5,4.5,7}, rounded half away
  // from zero, negated for odd q.
  function automatic int ref_res(input logic [63:0] w, input int k);
    int scale [16] = '{1, 7, 21, 45, 84, 138, 211, 304, 421, 562, 731, 928,
                       1157, 1419, 1715, 2048};
    int quarters [4] = '{3, 10, 18, 28};
    int sf, q, mag;
    sf  = int'(w[63:60]);
    q   = int'((w >> (57 - 3 * k)) & 64'h7);
    mag = (scale[sf] * quarters[q / 2] + 2) / 4;
    return (q % 2 == 1) ? -mag : mag;
  endfunction

  task automatic push_slice(input logic [63:0] w);
    for (int k = 0; k < 20; k++) sb.push_back('{val: ref_res(w, k), idx: k});
  endtask

  task automatic idle_cycle();
    data_rdy = 1'b0;
    byte_in  = 8'($urandom);
    @(posedge sys_clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    data_rdy = 1'b1;
    byte_in  = b;
    @(posedge sys_clk); #1;
    data_rdy = 1'b0;
    byte_in  = 8'($urandom);
  endtask

  task automatic send_bytes(input logic [63:0] w, input int first, input int last,
                            input bit gaps);
    for (int i = first; i <= last; i++) begin
      if (gaps) begin
        int n = int'($urandom_range(0, 3));
        for (int g = 0; g < n; g++) idle_cycle();
      end
      send_byte(w[63 - 8 * i -: 8]);
    end
  endtask

  task automatic wait_empty(input string name, input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      @(posedge sys_clk); #1;
      n++;
    end
    chk({name, "_pending"}, sb.size(), 0);
  endtask

  task automatic wait_index(input int idx, input int budget, output bit ok);
    int n = 0;
    while (!(res_valid && int'(res_index) == idx) && n < budget) begin
      @(posedge sys_clk); #1;
      n++;
    end
    ok = (n < budget);
    chk("wait_index_timeout", int'(!ok), 0);
  endtask

  task automatic check_zero_outputs(input string name);
    chk({name, "_valid"},    int'(res_valid), 0);
    chk({name, "_value"},    int'(res_value), 0);
    chk({name, "_index"},    int'(res_index), 0);
    chk({name, "_done"},     int'(slice_done), 0);
    chk({name, "_overflow"}, int'(overflow), 0);
  endtask

  // Ready driver.
  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge sys_clk); #1;
      case (ready_mode)
        0:       res_ready = 1'b1;
        1:       res_ready = 1'($urandom_range(0, 1));
        default: res_ready = 1'b0;
      endcase
    end
  end

  // Monitor: sampled on the falling edge, away from the active edge.
  initial begin
    bit   stall = 1'b0;
    int   pv = 0;
    int   pi = 0;
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst_n) begin
        stall = 1'b0;
        continue;
      end
      if (stall) begin
        chk("stall_valid", int'(res_valid), 1);
        chk("stall_value", int'(res_value), pv);
        chk("stall_index", int'(res_index), pi);
      end
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_transfer: got idx %0d value %0d, expected no transfer",
                   res_index, res_value);
        end else begin
          e = sb.pop_front();
          chk("res_value", int'(res_value), e.val);
          chk("res_index", int'(res_index), e.idx);
          chk("slice_done", int'(slice_done), int'(e.idx == 19));
        end
      end else begin
        chk("done_idle", int'(slice_done), 0);
      end
      stall = res_valid && !res_ready;
      pv    = int'(res_value);
      pi    = int'(res_index);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] w, w2;
    bit ok;
    sys_rst_n = 1'b0;
    data_rdy  = 1'b0;
    byte_in   = 8'h00;
    slice_clr = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    check_zero_outputs("reset");
    sys_rst_n = 1'b1;
    idle_cycle();

    // All-zero slice with latency check.
    ready_mode = 0;
    w = 64'h0;
    push_slice(w);
    send_bytes(w, 0, 6, 1'b0);
    chk("latency_before", int'(res_valid), 0);
    send_byte(w[7:0]);
    chk("latency_after", int'(res_valid), 1);
    wait_empty("zeros", 60);

    // All-ones slice: most negative residual.
    w = '1;
    push_slice(w);
    send_bytes(w, 0, 7, 1'b0);
    wait_empty("ones", 60);

    // sf=1, first residual q=1, rest q=0.
    w = 64'h1200_0000_0000_0000;
    push_slice(w);
    send_bytes(w, 0, 7, 1'b0);
    wait_empty("sf1", 60);

    // Random slices with random backpressure and byte gaps.
    ready_mode = 1;
    for (int s = 0; s < 8; s++) begin
      w = {32'($urandom), 32'($urandom)};
      push_slice(w);
      send_bytes(w, 0, 7, 1'b1);
      wait_empty("random", 400);
    end

    // Overflow: second slice completes while the first is stalled.
    ready_mode = 2;
    idle_cycle();
    w  = {32'($urandom), 32'($urandom)};
    w2 = {32'($urandom), 32'($urandom)};
    push_slice(w);
    send_bytes(w, 0, 7, 1'b0);
    send_bytes(w2, 0, 7, 1'b1);
    chk("overflow_set", int'(overflow), 1);
    chk("overflow_index", int'(res_index), 0);
    ready_mode = 0;
    wait_empty("overflow", 60);
    repeat (5) idle_cycle();
    chk("overflow_dropped", int'(res_valid), 0);

    // Next slice completing on the residual-19 accept.
    w  = {32'($urandom), 32'($urandom)};
    w2 = {32'($urandom), 32'($urandom)};
    push_slice(w);
    push_slice(w2);
    send_bytes(w, 0, 7, 1'b0);
    send_bytes(w2, 0, 6, 1'b0);
    wait_index(19, 40, ok);
    send_byte(w2[7:0]);
    chk("seamless_valid", int'(res_valid), 1);
    chk("seamless_index", int'(res_index), 0);
    wait_empty("seamless", 60);
    chk("overflow_sticky", int'(overflow), 1);

    // Reset mid-emission at index 7.
    w = {32'($urandom), 32'($urandom)};
    push_slice(w);
    send_bytes(w, 0, 7, 1'b0);
    wait_index(7, 40, ok);
    sys_rst_n = 1'b0;
    sb.delete();
    #1;
    check_zero_outputs("rst_emit");
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    repeat (10) idle_cycle();
    chk("rst_emit_quiet", int'(res_valid), 0);

    // Reset after 4 bytes of a slice.
    w = {32'($urandom), 32'($urandom)};
    send_bytes(w, 0, 3, 1'b0);
    sys_rst_n = 1'b0;
    #1;
    check_zero_outputs("rst_asm");
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    w = {32'($urandom), 32'($urandom)};
    push_slice(w);
    send_bytes(w, 0, 7, 1'b1);
    wait_empty("rst_asm", 60);

    // slice_clr after 3 bytes, coinciding with a byte that must be dropped.
    w = {32'($urandom), 32'($urandom)};
    send_bytes(w, 0, 2, 1'b0);
    slice_clr = 1'b1;
    send_byte(8'($urandom));
    slice_clr = 1'b0;
    w = {32'($urandom), 32'($urandom)};
    push_slice(w);
    send_bytes(w, 0, 7, 1'b1);
    wait_empty("clr", 60);
    repeat (5) idle_cycle();
    chk("final_idle", int'(res_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
